// File: rtl/fp32_div_seq.sv
// Sequential binary32 divider: restoring division on 24-bit significands,
// one quotient bit per cycle, truncating, with start/busy/done handshake.
module fp32_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] res,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);
    // state | meaning
    // IDLE  | waiting for start
    // DIV   | one restoring iteration per cycle, 25 in total
    // PACK  | normalise, register result and flags, pulse done
    typedef enum logic [1:0] {IDLE, DIV, PACK} state_t;

    state_t      state_q, state_d;
    logic [24:0] r_q, r_d;
    logic [24:0] q_q, q_d;
    logic [23:0] mb_q, mb_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [9:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        sp_exc_q, sp_exc_d;
    logic        sp_zero_q, sp_zero_d;
    logic [31:0] res_q, res_d;
    logic        exception_q, exception_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        done_q, done_d;

    logic        in_exc, in_zero;
    logic        q_bit;
    logic [24:0] r_rem;
    logic [9:0]  e_norm;
    logic [22:0] frac;

    assign in_exc  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (b[30:23] == 8'h00);
    assign in_zero = (a[30:23] == 8'h00);

    assign q_bit  = (r_q >= {1'b0, mb_q});
    assign r_rem  = q_bit ? (r_q - {1'b0, mb_q}) : r_q;
    assign e_norm = q_q[24] ? exp_q : (exp_q - 10'd1);
    assign frac   = q_q[24] ? q_q[23:1] : q_q[22:0];

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        mb_d        = mb_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        sp_exc_d    = sp_exc_q;
        sp_zero_d   = sp_zero_q;
        res_d       = res_q;
        exception_d = exception_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d    = a[31] ^ b[31];
                    r_d       = {2'b01, a[22:0]};
                    mb_d      = {1'b1, b[22:0]};
                    q_d       = 25'd0;
                    cnt_d     = 5'd0;
                    exp_d     = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
                    sp_exc_d  = in_exc;
                    sp_zero_d = in_zero && !in_exc;
                    state_d   = (in_exc || in_zero) ? PACK : DIV;
                end
            end
            DIV: begin
                r_d = {r_rem[23:0], 1'b0};
                q_d = {q_q[23:0], q_bit};
                if (cnt_q == 5'd24) begin
                    state_d = PACK;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            PACK: begin
                exception_d = 1'b0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
                if (sp_exc_q) begin
                    res_d       = 32'h0000_0000;
                    exception_d = 1'b1;
                end else if (sp_zero_q) begin
                    res_d = 32'h0000_0000;
                end else if ($signed(e_norm) >= 10'sd255) begin
                    res_d      = {sign_q, 8'hFF, 23'd0};
                    overflow_d = 1'b1;
                end else if ($signed(e_norm) <= 10'sd0) begin
                    res_d       = {sign_q, 31'd0};
                    underflow_d = 1'b1;
                end else begin
                    res_d = {sign_q, e_norm[7:0], frac};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            mb_q        <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            sp_exc_q    <= 1'b0;
            sp_zero_q   <= 1'b0;
            res_q       <= '0;
            exception_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            mb_q        <= mb_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            sp_exc_q    <= sp_exc_d;
            sp_zero_q   <= sp_zero_d;
            res_q       <= res_d;
            exception_q <= exception_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign res       = res_q;
    assign exception = exception_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_fp32_div_seq.sv
// Bench for fp32_div_seq: directed plan plus random operands against an
// integer-arithmetic reference model.
module tb_fp32_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, exception, overflow, underflow;
    logic [31:0] res;

    int n_checks = 0;
    int n_errors = 0;

    fp32_div_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .res(res),
        .exception(exception), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {special, exception, overflow, underflow, res}
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        int unsigned ex, ey;
        longint unsigned mx, my, qt;
        int          e;
        logic [22:0] fr;
        logic        s;
        ex = x[30:23];
        ey = y[30:23];
        s  = x[31] ^ y[31];
        if (ex == 255 || ey == 255 || ey == 0) return {4'b1100, 32'h0};
        if (ex == 0) return {4'b1000, 32'h0};
        mx = 64'h80_0000 + x[22:0];
        my = 64'h80_0000 + y[22:0];
        qt = (mx << 24) / my;
        e  = int'(ex) - int'(ey) + 127;
        if (qt >= 64'h100_0000) begin
            fr = 23'((qt >> 1) & 64'h7F_FFFF);
        end else begin
            fr = 23'(qt & 64'h7F_FFFF);
            e  = e - 1;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0001, s, 31'h0};
        return {4'b0000, s, 8'(e), fr};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
        logic [35:0] m;
        int lat;
        m = model(x, y);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, m[35] ? 32'd1 : 32'd26);
        check({tag, " res"}, res, m[31:0]);
        check({tag, " flags"}, {29'd0, exception, overflow, underflow}, {29'd0, m[34:32]});
        check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] x, y;
        logic [35:0] m;
        int lat, ndone;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset outputs", {res[31:5], busy, done, exception, overflow, underflow}, 32'd0);
        check("reset res", res, 32'd0);

        run_op("6/1.5", 32'h40C00000, 32'h3FC00000);
        check("6/1.5 const", res, 32'h40800000);
        run_op("1/3", 32'h3F800000, 32'h40400000);
        check("1/3 const", res, 32'h3EAAAAAA);
        run_op("-10/4", 32'hC1200000, 32'h40800000);
        check("-10/4 const", res, 32'hC0200000);
        run_op("2^24/2^12", 32'h4B800000, 32'h45800000);
        check("2^24/2^12 const", res, 32'h45800000);

        run_op("x/0", 32'h3F800000, 32'h00000000);
        check("x/0 exc", {31'd0, exception}, 32'd1);
        run_op("inf/1", 32'h7F800000, 32'h3F800000);
        run_op("0/5", 32'h00000000, 32'h40A00000);
        run_op("ovf", 32'h7F000000, 32'h3F000000);
        check("ovf const", {res[31:1], overflow}, {31'h3FC00000, 1'b1});
        run_op("unf", 32'h00800000, 32'h40000000);
        run_op("neg unf", 32'h80800000, 32'h40000000);
        check("neg unf const", res, 32'h80000000);

        // start pulse mid-division must be ignored
        x = 32'h40490FDB;
        y = 32'h402DF854;
        m = model(x, y);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 10;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore latency", lat, 32'd26);
        check("ignore res", res, m[31:0]);
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("ignore no second done", ndone, 32'd0);
        check("ignore hold res", res, m[31:0]);

        // reset mid-division aborts without a done
        a = 32'h41200000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort outputs", {27'd0, busy, done, exception, overflow, underflow}, 32'd0);
        check("abort res", res, 32'd0);
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort no done", ndone, 32'd0);
        run_op("after abort", 32'h41200000, 32'h40400000);

        // random operands, mostly finite normals, issued back-to-back
        for (int i = 0; i < 150; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                x[30:23] = 8'($urandom_range(1, 254));
                y[30:23] = 8'($urandom_range(1, 254));
            end
            run_op("random", x, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
